measurement_sequencer: RTL and testbench

//  Sequences the DataPath for repeated signal-strength measurements: enables it, discards

---
 rtl/measurement_sequencer.sv | 156 +++++++++++++++
 tb/tb_measurement_sequencer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/measurement_sequencer.sv
// rtl/measurement_sequencer.sv - settle/average/peak sequencer between DataPath and DataFramer
// Discards settling samples, averages and peak-tracks a burst, hands off one result, then idles for a gap.
module measurement_sequencer #(
  parameter int DATA_W         = 16,
  parameter int SETTLE_SAMPLES = 16,
  parameter int AVG_LOG2       = 4,
  parameter int GAP_CYCLES     = 125_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run_i,
  output logic              datapath_en_o,
  input  logic [DATA_W-1:0] db_i,
  input  logic              db_valid_i,
  output logic [DATA_W-1:0] avg_o,
  output logic [DATA_W-1:0] peak_o,
  output logic [7:0]        seq_o,
  output logic              result_valid_o,
  input  logic              result_ready_i,
  output logic              busy_o
);

  localparam int SUM_W   = DATA_W + AVG_LOG2;
  localparam int BURST   = 1 << AVG_LOG2;
  localparam int GAP_N   = (GAP_CYCLES < 1) ? 1 : GAP_CYCLES;
  localparam int CNT_MAX = (SETTLE_SAMPLES > BURST) ? SETTLE_SAMPLES : BURST;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int GAP_W   = $clog2(GAP_N + 1);

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_SAMPLES - 1);
  localparam logic [CNT_W-1:0] BURST_LAST  = CNT_W'(BURST - 1);
  localparam logic [GAP_W-1:0] GAP_LAST    = GAP_W'(GAP_N - 1);

  typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_ACCUM, S_OUTPUT, S_GAP} state_t;

  localparam state_t START = (SETTLE_SAMPLES == 0) ? S_ACCUM : S_SETTLE;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [SUM_W-1:0]   sum_q, sum_d, sum_next;
  logic [DATA_W-1:0]  peak_acc_q, peak_acc_d;
  logic [DATA_W-1:0]  avg_q, avg_d;
  logic [DATA_W-1:0]  peak_q, peak_d;
  logic [7:0]         seq_q, seq_d;
  logic               en_q, en_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    gap_d      = gap_q;
    sum_d      = sum_q;
    peak_acc_d = peak_acc_q;
    avg_d      = avg_q;
    peak_d     = peak_q;
    seq_d      = seq_q;
    sum_next   = sum_q + SUM_W'(db_i);

    case (state_q)
      S_IDLE: begin
        cnt_d      = '0;
        sum_d      = '0;
        peak_acc_d = '0;
        if (run_i) state_d = START;
      end
      S_SETTLE: begin
        if (!run_i) begin
          state_d = S_IDLE;
        end else if (db_valid_i) begin
          // The strobe that completes settling is consumed here, never accumulated.
          if (cnt_q == SETTLE_LAST) begin
            cnt_d   = '0;
            state_d = S_ACCUM;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_ACCUM: begin
        if (!run_i) begin
          state_d = S_IDLE;
        end else if (db_valid_i) begin
          sum_d      = sum_next;
          peak_acc_d = (cnt_q == '0 || db_i > peak_acc_q) ? db_i : peak_acc_q;
          cnt_d      = cnt_q + CNT_W'(1);
          if (cnt_q == BURST_LAST) begin
            state_d = S_OUTPUT;
            avg_d   = sum_next[SUM_W-1:AVG_LOG2];
            peak_d  = peak_acc_d;
          end
        end
      end
      S_OUTPUT: begin
        if (result_ready_i) begin
          seq_d   = seq_q + 8'd1;
          gap_d   = '0;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d    = run_i ? START : S_IDLE;
          cnt_d      = '0;
          sum_d      = '0;
          peak_acc_d = '0;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Flag outputs follow the next state so they change on the same edge as it.
    en_d    = (state_d == S_SETTLE) || (state_d == S_ACCUM);
    valid_d = (state_d == S_OUTPUT);
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      gap_q      <= '0;
      sum_q      <= '0;
      peak_acc_q <= '0;
      avg_q      <= '0;
      peak_q     <= '0;
      seq_q      <= '0;
      en_q       <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      gap_q      <= gap_d;
      sum_q      <= sum_d;
      peak_acc_q <= peak_acc_d;
      avg_q      <= avg_d;
      peak_q     <= peak_d;
      seq_q      <= seq_d;
      en_q       <= en_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
    end
  end

  assign datapath_en_o  = en_q;
  assign result_valid_o = valid_q;
  assign busy_o         = busy_q;
  assign avg_o          = avg_q;
  assign peak_o         = peak_q;
  assign seq_o          = seq_q;

endmodule

// File: tb/tb_measurement_sequencer.sv
// tb/tb_measurement_sequencer.sv - scoreboard bench for measurement_sequencer
// Stimulus pushes expected results; a negedge monitor pops and compares on each accepted result.
module tb_measurement_sequencer;
  localparam int DATA_W = 16;
  localparam int SETTLE = 3;
  localparam int GAP    = 10;
  localparam int N      = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              run_i;
  logic              datapath_en_o;
  logic [DATA_W-1:0] db_i;
  logic              db_valid_i;
  logic [DATA_W-1:0] avg_o;
  logic [DATA_W-1:0] peak_o;
  logic [7:0]        seq_o;
  logic              result_valid_o;
  logic              result_ready_i;
  logic              busy_o;

  measurement_sequencer #(
    .DATA_W(DATA_W), .SETTLE_SAMPLES(SETTLE), .AVG_LOG2(4), .GAP_CYCLES(GAP)
  ) dut (
    .clk(clk), .rst(rst), .run_i(run_i), .datapath_en_o(datapath_en_o),
    .db_i(db_i), .db_valid_i(db_valid_i), .avg_o(avg_o), .peak_o(peak_o),
    .seq_o(seq_o), .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] avg;
    logic [15:0] peak;
    logic [7:0]  seq;
  } res_t;

  res_t        exp_q[$];
  logic [7:0]  exp_seq = 8'd0;
  logic [15:0] samp[N];
  int          vectors = 0;
  int          miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && result_valid_o && result_ready_i) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 32'd1, 32'd0);
      end else begin
        res_t r;
        r = exp_q.pop_front();
        check("sb_avg", avg_o, r.avg);
        check("sb_peak", peak_o, r.peak);
        check("sb_seq", seq_o, r.seq);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [15:0] v, input bit idle_before);
    if (idle_before) begin
      db_i = 16'h5A5A;
      db_valid_i = 1'b0;
      tick();
    end
    db_i = v;
    db_valid_i = 1'b1;
    tick();
    db_valid_i = 1'b0;
    db_i = 16'hBEEF;
  endtask

  task automatic wait_en(output int n);
    n = 0;
    while (!datapath_en_o && n < 200) begin
      tick();
      n++;
    end
    if (!datapath_en_o) check("en_timeout", 32'd0, 32'd1);
  endtask

  // Settle strobes carry large junk values: if any were accumulated the result would be wrong.
  task automatic run_burst(input int hold);
    int          n;
    logic [19:0] sum;
    logic [15:0] pk;
    res_t        r;
    wait_en(n);
    for (int i = 0; i < SETTLE; i++) strobe(16'hF000 + 16'(i), i == 1);
    sum = '0;
    pk  = samp[0];
    for (int i = 0; i < N; i++) begin
      sum += 20'(samp[i]);
      if (samp[i] > pk) pk = samp[i];
    end
    r.avg  = sum[19:4];
    r.peak = pk;
    r.seq  = exp_seq;
    exp_q.push_back(r);
    for (int i = 0; i < N; i++) strobe(samp[i], i == 5 || i == 11);
    check("valid_after_last", result_valid_o, 1);
    check("en_off_in_output", datapath_en_o, 0);
    for (int i = 0; i < hold; i++) begin
      tick();
      check("hold_valid", result_valid_o, 1);
      check("hold_avg", avg_o, r.avg);
      check("hold_peak", peak_o, r.peak);
      check("hold_seq", seq_o, r.seq);
    end
    if (!result_ready_i) begin
      result_ready_i = 1'b1;
      tick();
      result_ready_i = 1'b0;
    end else begin
      tick();
    end
    exp_seq++;
    check("valid_drop", result_valid_o, 0);
    check("seq_after_accept", seq_o, exp_seq);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1;
    run_i = 1'b0;
    db_i = '0;
    db_valid_i = 1'b0;
    result_ready_i = 1'b0;
    tick();
    check("rst_en", datapath_en_o, 0);
    check("rst_valid", result_valid_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_avg", avg_o, 0);
    check("rst_peak", peak_o, 0);
    check("rst_seq", seq_o, 0);
    rst = 1'b0;
    tick();
    tick();
    check("idle_busy", busy_o, 0);

    // constant 100 burst, enable one cycle after run_i sampled
    run_i = 1'b1;
    check("en_before_run", datapath_en_o, 0);
    tick();
    check("en_after_run", datapath_en_o, 1);
    check("busy_after_run", busy_o, 1);
    for (int i = 0; i < N; i++) samp[i] = 16'd100;
    run_burst(3);

    // ramp 0..15 held 50 cycles (avg 7, peak 15)
    for (int i = 0; i < N; i++) samp[i] = 16'(i);
    run_burst(50);

    // gap: acceptance cycle to enable rise
    wait_en(n);
    check("gap_cycles", 32'(n + 1), 32'd11);

    // saturated burst, accumulator must not overflow
    for (int i = 0; i < N; i++) samp[i] = 16'hFFFF;
    run_burst(2);

    // abort after 5 accumulate strobes
    result_ready_i = 1'b1;
    wait_en(n);
    for (int i = 0; i < SETTLE; i++) strobe(16'h1234, 1'b0);
    for (int i = 0; i < 5; i++) strobe(16'd50, 1'b0);
    check("abort_en_before", datapath_en_o, 1);
    run_i = 1'b0;
    tick();
    check("abort_en", datapath_en_o, 0);
    check("abort_busy", busy_o, 0);
    check("abort_valid", result_valid_o, 0);
    check("abort_seq", seq_o, exp_seq);
    for (int i = 0; i < 20; i++) tick();
    check("abort_no_result", result_valid_o, 0);

    // continuous run with ready held high until seq wraps
    run_i = 1'b1;
    for (int k = 0; k < 300 && !(k > 0 && exp_seq == 8'd0); k++) begin
      for (int i = 0; i < N; i++) samp[i] = 16'(k * 37 + i * (k % 5));
      run_burst(0);
    end
    check("seq_wrap", seq_o, 0);

    // one more burst then drop run_i during the gap
    for (int i = 0; i < N; i++) samp[i] = 16'(200 - i);
    run_burst(0);
    run_i = 1'b0;
    result_ready_i = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    check("gap_busy", busy_o, 1);
    check("gap_en", datapath_en_o, 0);
    tick();
    check("gap_done_busy", busy_o, 0);
    check("gap_done_en", datapath_en_o, 0);

    // async reset mid-accumulate
    run_i = 1'b1;
    wait_en(n);
    for (int i = 0; i < SETTLE; i++) strobe(16'h0777, 1'b0);
    for (int i = 0; i < 4; i++) strobe(16'h0900, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("arst_en", datapath_en_o, 0);
    check("arst_busy", busy_o, 0);
    check("arst_seq", seq_o, 0);
    check("arst_avg", avg_o, 0);
    check("arst_peak", peak_o, 0);
    check("arst_valid", result_valid_o, 0);
    exp_seq = 8'd0;
    for (int i = 0; i < 3; i++) begin
      db_i = 16'hFFFF;
      db_valid_i = 1'b1;
      tick();
    end
    db_valid_i = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < N; i++) samp[i] = 16'd1000 + 16'(i);
    run_burst(2);

    run_i = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
